// File: rtl/my_mc_controller.sv
// my_mc_controller: multi-cycle processor control FSM (fetch/decode/execute/writeback, mult timing, illegal trap)
module my_mc_controller #(
  parameter int         MULT_CYCLES = 32,
  parameter logic [7:0] TRAP_STATE  = 8'd255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mem_ready,
  input  logic [7:0] i_dispatch,
  input  logic       i_zero,
  input  logic       i_gtz,
  output logic [7:0] o_state,
  output logic       o_mem_read,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic [1:0] o_pc_source,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_op,
  output logic       o_reg_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_wb_src,
  output logic       o_mult_start,
  output logic       o_lo_write,
  output logic       o_busy_mult,
  output logic       o_illegal
);
  localparam int CW = $clog2(MULT_CYCLES);
  typedef enum logic [7:0] {
    FETCH = 8'd0, DECODE = 8'd1,
    SRAV_EX = 8'd2, SRAV_WB = 8'd3, ADDI_EX = 8'd4, ADDI_WB = 8'd5,
    NOR_EX = 8'd6, NOR_WB = 8'd7, XORI_EX = 8'd8, XORI_WB = 8'd9,
    SLT_EX = 8'd10, SLT_WB = 8'd11, SLTI_EX = 8'd12, SLTI_WB = 8'd13,
    BEQ = 8'd14, BGTZ = 8'd16, JAL = 8'd18, MULT = 8'd20, MULT_WAIT = 8'd21,
    MFLO_EX = 8'd22, MFLO_WB = 8'd23, JR = 8'd24
  } state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  assign o_state = state;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= state == MULT ? CW'(MULT_CYCLES - 2) : state == MULT_WAIT && cnt != '0 ? cnt - 1'b1 : cnt;
    end
  // All outputs stay 0 while reset is held; only FETCH looks at i_mem_ready.
  always_comb begin
    next = FETCH;
    o_mem_read = 1'b0;
    o_ir_write = 1'b0;
    o_pc_write = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_source = 2'd0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 2'd0;
    o_alu_op = 3'd0;
    o_reg_write = 1'b0;
    o_reg_dst = 2'd0;
    o_wb_src = 2'd0;
    o_mult_start = 1'b0;
    o_lo_write = 1'b0;
    o_busy_mult = 1'b0;
    o_illegal = 1'b0;
    if (!i_rst)
      case (state)
        FETCH: begin
          o_mem_read = 1'b1;
          o_alu_src_b = 2'd1;
          o_ir_write = i_mem_ready;
          o_pc_write = i_mem_ready;
          next = i_mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          o_alu_src_b = 2'd3;
          case (i_dispatch)
            8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12,
            8'd14, 8'd16, 8'd18, 8'd20, 8'd22, 8'd24: next = state_t'(i_dispatch);
            default: next = state_t'(TRAP_STATE);
          endcase
        end
        SRAV_EX: begin o_alu_src_a = 1'b1; o_alu_op = 3'd2; next = SRAV_WB; end
        ADDI_EX: begin o_alu_src_a = 1'b1; o_alu_src_b = 2'd2; next = ADDI_WB; end
        NOR_EX: begin o_alu_src_a = 1'b1; o_alu_op = 3'd3; next = NOR_WB; end
        XORI_EX: begin o_alu_src_a = 1'b1; o_alu_src_b = 2'd2; o_alu_op = 3'd5; next = XORI_WB; end
        SLT_EX: begin o_alu_src_a = 1'b1; o_alu_op = 3'd4; next = SLT_WB; end
        SLTI_EX: begin o_alu_src_a = 1'b1; o_alu_src_b = 2'd2; o_alu_op = 3'd4; next = SLTI_WB; end
        SRAV_WB, NOR_WB, SLT_WB: begin o_reg_write = 1'b1; o_reg_dst = 2'd1; end
        ADDI_WB, XORI_WB, SLTI_WB: o_reg_write = 1'b1;
        BEQ: begin o_alu_src_a = 1'b1; o_alu_op = 3'd1; o_pc_source = 2'd1; o_pc_write_cond = i_zero; end
        BGTZ: begin o_pc_source = 2'd1; o_pc_write_cond = i_gtz; end
        JAL: begin o_pc_write = 1'b1; o_pc_source = 2'd2; o_reg_write = 1'b1; o_reg_dst = 2'd2; o_wb_src = 2'd1; end
        JR: begin o_pc_write = 1'b1; o_pc_source = 2'd3; end
        MULT: begin o_mult_start = 1'b1; next = MULT_WAIT; end
        MULT_WAIT: begin
          o_busy_mult = 1'b1;
          o_lo_write = cnt == '0;
          next = cnt == '0 ? FETCH : MULT_WAIT;
        end
        MFLO_EX: next = MFLO_WB;
        MFLO_WB: begin o_reg_write = 1'b1; o_reg_dst = 2'd1; o_wb_src = 2'd2; end
        default: o_illegal = state == TRAP_STATE;
      endcase
  end
endmodule

// File: tb/tb_my_mc_controller.sv
// tb_my_mc_controller: directed self-checking bench for my_mc_controller
module tb_my_mc_controller;
  logic i_clk = 1'b0, i_rst = 1'b1, i_mem_ready = 1'b0, i_zero = 1'b0, i_gtz = 1'b0;
  logic [7:0] i_dispatch = 8'd0;
  logic [7:0] o_state;
  logic o_mem_read, o_ir_write, o_pc_write, o_pc_write_cond, o_alu_src_a, o_reg_write;
  logic o_mult_start, o_lo_write, o_busy_mult, o_illegal;
  logic [1:0] o_pc_source, o_alu_src_b, o_reg_dst, o_wb_src;
  logic [2:0] o_alu_op;
  int total = 0, bad = 0;
  my_mc_controller dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_mem_ready(i_mem_ready), .i_dispatch(i_dispatch),
    .i_zero(i_zero), .i_gtz(i_gtz), .o_state(o_state), .o_mem_read(o_mem_read),
    .o_ir_write(o_ir_write), .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond),
    .o_pc_source(o_pc_source), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
    .o_alu_op(o_alu_op), .o_reg_write(o_reg_write), .o_reg_dst(o_reg_dst), .o_wb_src(o_wb_src),
    .o_mult_start(o_mult_start), .o_lo_write(o_lo_write), .o_busy_mult(o_busy_mult),
    .o_illegal(o_illegal)
  );
  always #5 i_clk = ~i_clk;
  task automatic tick;
    @(negedge i_clk);
    #1;
  endtask
  task automatic test_reset;
    #1;
    total++;
    if (o_state !== 8'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    total++;
    if ({o_mem_read, o_ir_write, o_pc_write, o_pc_write_cond, o_reg_write, o_mult_start, o_lo_write, o_busy_mult, o_illegal} !== 9'd0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0", {o_mem_read, o_ir_write, o_pc_write, o_pc_write_cond, o_reg_write, o_mult_start, o_lo_write, o_busy_mult, o_illegal});
    end
    total++;
    if ({o_pc_source, o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_dst, o_wb_src} !== 12'd0) begin
      bad++; $display("FAIL reset_selects got=%b exp=0", {o_pc_source, o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_dst, o_wb_src});
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
  endtask
  task automatic test_addi;
    logic [7:0] es [5] = '{8'd0, 8'd1, 8'd4, 8'd5, 8'd0};
    logic       rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       pw [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    i_mem_ready = 1'b1;
    i_dispatch = 8'd4;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      total++;
      if (o_state !== es[i]) begin bad++; $display("FAIL addi_state[%0d] got=%0d exp=%0d", i, o_state, es[i]); end
      total++;
      if (o_reg_write !== rw[i]) begin bad++; $display("FAIL addi_reg_write[%0d] got=%b exp=%b", i, o_reg_write, rw[i]); end
      total++;
      if (o_pc_write !== pw[i]) begin bad++; $display("FAIL addi_pc_write[%0d] got=%b exp=%b", i, o_pc_write, pw[i]); end
    end
  endtask
  task automatic test_fetch_wait;
    i_mem_ready = 1'b0;
    i_dispatch = 8'd2;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({o_state, o_mem_read, o_ir_write, o_pc_write} !== {8'd0, 3'b100}) begin
        bad++; $display("FAIL fetch_wait[%0d] got state=%0d rd/ir/pc=%b exp state=0 rd/ir/pc=100", i, o_state, {o_mem_read, o_ir_write, o_pc_write});
      end
      tick();
    end
    i_mem_ready = 1'b1;
    #1;
    total++;
    if ({o_state, o_mem_read, o_ir_write, o_pc_write} !== {8'd0, 3'b111}) begin
      bad++; $display("FAIL fetch_ready got state=%0d rd/ir/pc=%b exp state=0 rd/ir/pc=111", o_state, {o_mem_read, o_ir_write, o_pc_write});
    end
    tick();
    tick();
    total++;
    if ({o_state, o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_write} !== {8'd2, 1'b1, 2'd0, 3'd2, 1'b0}) begin
      bad++; $display("FAIL srav_exec got state=%0d a/b/op/rw=%b exp state=2 a/b/op/rw=1000100", o_state, {o_alu_src_a, o_alu_src_b, o_alu_op, o_reg_write});
    end
    tick();
    total++;
    if ({o_state, o_reg_write, o_reg_dst, o_wb_src} !== {8'd3, 1'b1, 2'd1, 2'd0}) begin
      bad++; $display("FAIL srav_wb got state=%0d rw/dst/wb=%b exp state=3 rw/dst/wb=10100", o_state, {o_reg_write, o_reg_dst, o_wb_src});
    end
    tick();
  endtask
  task automatic test_branch;
    logic [7:0] d  [4] = '{8'd14, 8'd14, 8'd16, 8'd16};
    logic       z  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       g  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       pc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      i_dispatch = d[i];
      i_zero = z[i];
      i_gtz = g[i];
      tick();
      tick();
      total++;
      if ({o_state, o_pc_source, o_pc_write_cond, o_pc_write, o_reg_write} !== {d[i], 2'd1, pc[i], 2'b00}) begin
        bad++; $display("FAIL branch[%0d] got state=%0d src=%0d cond=%b pcw=%b rw=%b exp state=%0d src=1 cond=%b pcw=0 rw=0",
                        i, o_state, o_pc_source, o_pc_write_cond, o_pc_write, o_reg_write, d[i], pc[i]);
      end
      if (d[i] == 8'd14) begin
        total++;
        if (o_alu_op !== 3'd1) begin bad++; $display("FAIL beq_alu_op got=%0d exp=1", o_alu_op); end
      end
      tick();
      total++;
      if (o_state !== 8'd0) begin bad++; $display("FAIL branch_return[%0d] got=%0d exp=0", i, o_state); end
    end
    i_zero = 1'b0;
    i_gtz = 1'b0;
  endtask
  task automatic test_jump;
    i_dispatch = 8'd18;
    tick();
    tick();
    total++;
    if ({o_state, o_pc_write, o_pc_source, o_reg_write, o_reg_dst, o_wb_src} !== {8'd18, 1'b1, 2'd2, 1'b1, 2'd2, 2'd1}) begin
      bad++; $display("FAIL jal got state=%0d pcw/src/rw/dst/wb=%b exp state=18 pcw/src/rw/dst/wb=11011001", o_state, {o_pc_write, o_pc_source, o_reg_write, o_reg_dst, o_wb_src});
    end
    i_dispatch = 8'd24;
    tick();
    tick();
    tick();
    total++;
    if ({o_state, o_pc_write, o_pc_source, o_reg_write} !== {8'd24, 1'b1, 2'd3, 1'b0}) begin
      bad++; $display("FAIL jr got state=%0d pcw/src/rw=%b exp state=24 pcw/src/rw=1110", o_state, {o_pc_write, o_pc_source, o_reg_write});
    end
    tick();
  endtask
  task automatic run_mult(input string tag);
    int busy_n = 0, lo_n = 0, lo_at = 0, cyc = 1;
    i_dispatch = 8'd20;
    tick();
    tick();
    total++;
    if ({o_state, o_mult_start, o_busy_mult, o_lo_write} !== {8'd20, 3'b100}) begin
      bad++; $display("FAIL %s_start got state=%0d start/busy/lo=%b exp state=20 start/busy/lo=100", tag, o_state, {o_mult_start, o_busy_mult, o_lo_write});
    end
    tick();
    while (o_state !== 8'd0 && cyc < 100) begin
      cyc++;
      busy_n += int'(o_busy_mult);
      if (o_lo_write) begin lo_n++; lo_at = cyc; end
      if (o_mult_start) begin bad++; total++; $display("FAIL %s_restart at cycle %0d got=1 exp=0", tag, cyc); end
      tick();
    end
    total++;
    if (busy_n !== 31) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=31", tag, busy_n); end
    total++;
    if (lo_n !== 1 || lo_at !== 32) begin bad++; $display("FAIL %s_lo_write got count=%0d at=%0d exp count=1 at=32", tag, lo_n, lo_at); end
  endtask
  task automatic test_mult;
    run_mult("mult");
    i_dispatch = 8'd22;
    tick();
    tick();
    total++;
    if ({o_state, o_reg_write} !== {8'd22, 1'b0}) begin bad++; $display("FAIL mflo_exec got state=%0d rw=%b exp state=22 rw=0", o_state, o_reg_write); end
    tick();
    total++;
    if ({o_state, o_reg_write, o_reg_dst, o_wb_src} !== {8'd23, 1'b1, 2'd1, 2'd2}) begin
      bad++; $display("FAIL mflo_wb got state=%0d rw/dst/wb=%b exp state=23 rw/dst/wb=10110", o_state, {o_reg_write, o_reg_dst, o_wb_src});
    end
    tick();
  endtask
  task automatic test_trap;
    logic [7:0] d [2] = '{8'hxx, 8'd3};
    for (int i = 0; i < 2; i++) begin
      i_dispatch = d[i];
      tick();
      tick();
      total++;
      if ({o_state, o_illegal, o_pc_write, o_pc_write_cond, o_reg_write, o_lo_write, o_mem_read} !== {8'd255, 6'b100000}) begin
        bad++; $display("FAIL trap[%0d] got state=%0d ill/pcw/cond/rw/lo/rd=%b exp state=255 ill/pcw/cond/rw/lo/rd=100000",
                        i, o_state, {o_illegal, o_pc_write, o_pc_write_cond, o_reg_write, o_lo_write, o_mem_read});
      end
      tick();
      total++;
      if ({o_state, o_illegal} !== {8'd0, 1'b0}) begin bad++; $display("FAIL trap_return[%0d] got state=%0d ill=%b exp state=0 ill=0", i, o_state, o_illegal); end
    end
  endtask
  task automatic test_reset_mult;
    i_dispatch = 8'd20;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if ({o_state, o_busy_mult} !== {8'd21, 1'b1}) begin bad++; $display("FAIL rstmult_pre got state=%0d busy=%b exp state=21 busy=1", o_state, o_busy_mult); end
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_state, o_busy_mult, o_lo_write, o_reg_write, o_mem_read} !== {8'd0, 4'b0000}) begin
      bad++; $display("FAIL rstmult_abort got state=%0d busy/lo/rw/rd=%b exp state=0 busy/lo/rw/rd=0000", o_state, {o_busy_mult, o_lo_write, o_reg_write, o_mem_read});
    end
    tick();
    total++;
    if ({o_state, o_lo_write} !== {8'd0, 1'b0}) begin bad++; $display("FAIL rstmult_hold got state=%0d lo=%b exp state=0 lo=0", o_state, o_lo_write); end
    i_rst = 1'b0;
    #1;
    run_mult("remult");
  endtask
  initial begin
    test_reset();
    test_addi();
    test_fetch_wait();
    test_branch();
    test_jump();
    test_mult();
    test_trap();
    test_reset_mult();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
